// File: rtl/channel_deadtime_insert.sv
// Complementary CHx/CHxN pad driver with programmable dead time after each reference edge.
// Optional break input and latched brk_flag are built when ADVTIM_DT_BREAK_EN is defined.
module channel_deadtime_insert #(
    parameter int NCH = 3,
    parameter int DTW = 8
) (
    input  logic           pe_gen_clk,
    input  logic           pe_gen_rst,
    input  logic           timing_enable,
    input  logic [NCH-1:0] ocrefc,
    input  logic [DTW-1:0] r_dtg,
    input  logic [NCH-1:0] r_cce,
    input  logic [NCH-1:0] r_ccne,
    input  logic [NCH-1:0] r_ccp,
    input  logic [NCH-1:0] r_ccnp,
    input  logic [NCH-1:0] r_ois,
    input  logic [NCH-1:0] r_oisn,
    input  logic           r_moe,
`ifdef ADVTIM_DT_BREAK_EN
    input  logic           brk,
    input  logic           r_bkp,
    input  logic           r_bif_clr,
`endif
    output logic [NCH-1:0] ch_o,
    output logic [NCH-1:0] ch_on,
    output logic           brk_flag
);

    typedef enum logic [1:0] {ST_OFF, ST_NEG, ST_DT, ST_POS} state_t;
    typedef enum logic [1:0] {ORG_NONE, ORG_NEG, ORG_POS} origin_t;

    logic           moe_eff;
    logic           dt_zero;
    logic [DTW-1:0] dt_load;

    assign dt_zero = (r_dtg == '0);
    assign dt_load = r_dtg - DTW'(1);

`ifdef ADVTIM_DT_BREAK_EN
    logic [1:0] brk_sync_reg;
    logic       brk_flag_reg;
    logic       brk_flag_next;
    logic       brk_active;

    assign brk_active    = ~(brk_sync_reg[1] ^ r_bkp);
    // A set in the same cycle as a clear wins because brk_active dominates.
    assign brk_flag_next = brk_active | (brk_flag_reg & ~r_bif_clr);

    always_ff @(posedge pe_gen_clk) begin
        if (pe_gen_rst) begin
            brk_sync_reg <= {2{~r_bkp}};
            brk_flag_reg <= 1'b0;
        end else begin
            brk_sync_reg <= {brk_sync_reg[0], brk};
            brk_flag_reg <= brk_flag_next;
        end
    end

    assign brk_flag = brk_flag_reg;
    // Idle levels must appear on the same edge that latches the flag.
    assign moe_eff  = r_moe & ~brk_flag_next;
`else
    assign brk_flag = 1'b0;
    assign moe_eff  = r_moe;
`endif

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            state_t         state_reg;
            origin_t        origin_reg;
            logic [DTW-1:0] cnt_reg;
            logic [1:0]     pad_reg;
            logic [1:0]     idle_pad;
            logic [1:0]     pos_pad;
            logic [1:0]     neg_pad;
            logic [1:0]     dead_pad;
            logic [1:0]     side_pad;
            logic           ref_bit;

            assign ref_bit  = ocrefc[gi];
            assign idle_pad = {r_ois[gi], r_oisn[gi]};
            // Pad levels for raw pairs POS={1,0}, NEG={0,1} and dead={0,0}.
            assign pos_pad  = moe_eff ? {r_cce[gi] ? ~r_ccp[gi] : r_ccp[gi], r_ccnp[gi]} : idle_pad;
            assign neg_pad  = moe_eff ? {r_ccp[gi], r_ccne[gi] ? ~r_ccnp[gi] : r_ccnp[gi]} : idle_pad;
            assign dead_pad = moe_eff ? {r_ccp[gi], r_ccnp[gi]} : idle_pad;
            assign side_pad = ref_bit ? pos_pad : neg_pad;

            always_ff @(posedge pe_gen_clk) begin
                if (pe_gen_rst) begin
                    state_reg  <= ST_OFF;
                    origin_reg <= ORG_NONE;
                    cnt_reg    <= '0;
                    pad_reg    <= 2'b00;
                end else if (!timing_enable) begin
                    state_reg  <= ST_OFF;
                    origin_reg <= ORG_NONE;
                    cnt_reg    <= '0;
                    pad_reg    <= dead_pad;
                end else begin
                    case (state_reg)
                        ST_OFF: begin
                            if (dt_zero) begin
                                state_reg <= ref_bit ? ST_POS : ST_NEG;
                                pad_reg   <= side_pad;
                            end else begin
                                state_reg  <= ST_DT;
                                cnt_reg    <= dt_load;
                                origin_reg <= ORG_NONE;
                                pad_reg    <= dead_pad;
                            end
                        end
                        ST_NEG: begin
                            if (ref_bit && dt_zero) begin
                                state_reg <= ST_POS;
                                pad_reg   <= pos_pad;
                            end else if (ref_bit) begin
                                state_reg  <= ST_DT;
                                cnt_reg    <= dt_load;
                                origin_reg <= ORG_NEG;
                                pad_reg    <= dead_pad;
                            end else begin
                                pad_reg <= neg_pad;
                            end
                        end
                        ST_POS: begin
                            if (!ref_bit && dt_zero) begin
                                state_reg <= ST_NEG;
                                pad_reg   <= neg_pad;
                            end else if (!ref_bit) begin
                                state_reg  <= ST_DT;
                                cnt_reg    <= dt_load;
                                origin_reg <= ORG_POS;
                                pad_reg    <= dead_pad;
                            end else begin
                                pad_reg <= pos_pad;
                            end
                        end
                        ST_DT: begin
                            // A reference that returns to the origin side cancels the pending switch.
                            if ((origin_reg == ORG_NEG && !ref_bit) ||
                                (origin_reg == ORG_POS && ref_bit) || cnt_reg == '0) begin
                                state_reg  <= ref_bit ? ST_POS : ST_NEG;
                                cnt_reg    <= '0;
                                origin_reg <= ORG_NONE;
                                pad_reg    <= side_pad;
                            end else begin
                                cnt_reg <= cnt_reg - DTW'(1);
                                pad_reg <= dead_pad;
                            end
                        end
                        default: begin
                            state_reg <= ST_OFF;
                            pad_reg   <= dead_pad;
                        end
                    endcase
                end
            end

            assign ch_o[gi]  = pad_reg[1];
            assign ch_on[gi] = pad_reg[0];
        end
    endgenerate

endmodule

// File: tb/tb_channel_deadtime_insert.sv
// Self-checking bench for channel_deadtime_insert: constant vectors, corner sequences,
// and randomized traffic against an edge/dead-time reference model.
`timescale 1ns/1ps
module tb_channel_deadtime_insert;
    localparam int NCH = 3;
    localparam int DTW = 8;

    logic           clk = 1'b0;
    logic           srst;
    logic           te;
    logic [NCH-1:0] ocrefc;
    logic [DTW-1:0] dtg;
    logic [NCH-1:0] cce, ccne, ccp, ccnp, ois, oisn;
    logic           moe;
    logic [NCH-1:0] ch_o, ch_on;
    logic           brk_flag;
`ifdef ADVTIM_DT_BREAK_EN
    logic           brk, r_bkp, r_bif_clr;
`endif

    int n_pass = 0;
    int n_total = 0;

    channel_deadtime_insert #(.NCH(NCH), .DTW(DTW)) dut (
        .pe_gen_clk    (clk),
        .pe_gen_rst    (srst),
        .timing_enable (te),
        .ocrefc        (ocrefc),
        .r_dtg         (dtg),
        .r_cce         (cce),
        .r_ccne        (ccne),
        .r_ccp         (ccp),
        .r_ccnp        (ccnp),
        .r_ois         (ois),
        .r_oisn        (oisn),
        .r_moe         (moe),
`ifdef ADVTIM_DT_BREAK_EN
        .brk           (brk),
        .r_bkp         (r_bkp),
        .r_bif_clr     (r_bif_clr),
`endif
        .ch_o          (ch_o),
        .ch_on         (ch_on),
        .brk_flag      (brk_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic           te;
        logic [NCH-1:0] refv, cce, ccne, ccp, ccnp, ois, oisn;
        logic           moe;
        logic [NCH-1:0] exp_o, exp_on;
    } vec_t;

    vec_t vecs[9];

    // Reference model: settled side (-1 off, 0 neg, 1 pos), dead cycles still to show, side left.
    int m_side[NCH];
    int m_dead[NCH];
    int m_home[NCH];
    logic [NCH-1:0] exp_o, exp_on;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_defaults();
        te = 1'b1; ocrefc = '0; dtg = '0;
        cce = '1; ccne = '1; ccp = '0; ccnp = '0; ois = '0; oisn = '0; moe = 1'b1;
`ifdef ADVTIM_DT_BREAK_EN
        brk = 1'b0; r_bkp = 1'b1; r_bif_clr = 1'b0;
`endif
    endtask

    task automatic do_reset();
        srst = 1'b1;
        tick();
        tick();
        srst = 1'b0;
    endtask

    task automatic model_step();
        for (int c = 0; c < NCH; c++) begin
            int r;
            logic p, n;
            r = int'(ocrefc[c]);
            if (!te) begin
                m_side[c] = -1;
                m_dead[c] = 0;
            end else if (m_dead[c] > 0) begin
                if (m_home[c] >= 0 && r == m_home[c]) begin
                    m_side[c] = m_home[c];
                    m_dead[c] = 0;
                end else if (m_dead[c] == 1) begin
                    m_side[c] = r;
                    m_dead[c] = 0;
                end else begin
                    m_dead[c]--;
                end
            end else if (m_side[c] != r) begin
                if (dtg == 0) m_side[c] = r;
                else begin
                    m_home[c] = m_side[c];
                    m_dead[c] = int'(dtg);
                end
            end
            p = (m_dead[c] == 0 && m_side[c] == 1);
            n = (m_dead[c] == 0 && m_side[c] == 0);
            if (!moe) begin
                exp_o[c]  = ois[c];
                exp_on[c] = oisn[c];
            end else begin
                exp_o[c]  = cce[c]  ? (p ^ ccp[c])  : ccp[c];
                exp_on[c] = ccne[c] ? (n ^ ccnp[c]) : ccnp[c];
            end
        end
    endtask

    initial begin
        int k, lowc, bad;
        logic o_seen, on_bad;

        vecs[0] = '{1'b1, 3'b101, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 3'b101, 3'b010};
        vecs[1] = '{1'b1, 3'b101, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 3'b010, 3'b010};
        vecs[2] = '{1'b1, 3'b011, 3'b111, 3'b111, 3'b000, 3'b111, 3'b000, 3'b000, 1'b1, 3'b011, 3'b011};
        vecs[3] = '{1'b1, 3'b110, 3'b000, 3'b000, 3'b101, 3'b011, 3'b000, 3'b000, 1'b1, 3'b101, 3'b011};
        vecs[4] = '{1'b1, 3'b110, 3'b111, 3'b111, 3'b000, 3'b000, 3'b101, 3'b010, 1'b0, 3'b101, 3'b010};
        vecs[5] = '{1'b0, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 3'b000, 3'b000};
        vecs[6] = '{1'b0, 3'b111, 3'b111, 3'b111, 3'b110, 3'b001, 3'b000, 3'b000, 1'b1, 3'b110, 3'b001};
        vecs[7] = '{1'b1, 3'b011, 3'b010, 3'b100, 3'b001, 3'b010, 3'b000, 3'b000, 1'b1, 3'b011, 3'b110};
        vecs[8] = '{1'b1, 3'b100, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 3'b100, 3'b011};

        set_defaults();
        srst = 1'b1;
        tick();
        check("reset_ch_o", 8'(ch_o), 8'h00);
        check("reset_ch_on", 8'(ch_on), 8'h00);
        check("reset_brk_flag", 8'(brk_flag), 8'h00);
        srst = 1'b0;

        // Constant vectors with zero dead time: outputs follow inputs after one edge.
        for (int i = 0; i < 9; i++) begin
            te = vecs[i].te; ocrefc = vecs[i].refv; cce = vecs[i].cce; ccne = vecs[i].ccne;
            ccp = vecs[i].ccp; ccnp = vecs[i].ccnp; ois = vecs[i].ois; oisn = vecs[i].oisn;
            moe = vecs[i].moe;
            tick();
            $display("vec %0d ref=%b o=%b on=%b", i, ocrefc, ch_o, ch_on);
            check($sformatf("vec%0d_ch_o", i), 8'(ch_o), 8'(vecs[i].exp_o));
            check($sformatf("vec%0d_ch_on", i), 8'(ch_on), 8'(vecs[i].exp_on));
        end

        // Rising edge with four dead cycles.
        set_defaults(); dtg = 8'd4; do_reset();
        repeat (6) tick();
        check("t1_settle_on", 8'(ch_on), 8'h07);
        ocrefc = 3'b001;
        tick();
        check("t1_e0_on", 8'(ch_on[0]), 8'h00);
        k = 0; on_bad = 1'b0;
        while (!ch_o[0] && k < 20) begin
            tick();
            k++;
            if (ch_on[0] && !ch_o[0]) on_bad = 1'b1;
        end
        $display("t1 dead cycles=%0d", k);
        check("t1_dead_cycles", 8'(k), 8'd4);
        check("t1_on_held_low", 8'(on_bad), 8'h00);

        // Pulse shorter than the dead time is suppressed.
        set_defaults(); dtg = 8'd5; do_reset();
        repeat (8) tick();
        ocrefc = 3'b001; lowc = 0; o_seen = 1'b0;
        repeat (3) begin tick(); if (!ch_on[0]) lowc++; o_seen |= ch_o[0]; end
        ocrefc = 3'b000;
        repeat (6) begin tick(); if (!ch_on[0]) lowc++; o_seen |= ch_o[0]; end
        $display("t2 low cycles=%0d", lowc);
        check("t2_on_low_cycles", 8'(lowc), 8'd3);
        check("t2_o_never_high", 8'(o_seen), 8'h00);
        check("t2_on_restored", 8'(ch_on[0]), 8'h01);

        // Main output disabled: idle levels hold, phase is correct on re-enable.
        set_defaults(); moe = 1'b0; ois = 3'b101; oisn = 3'b010; dtg = 8'd2; do_reset();
        bad = 0;
        repeat (12) begin
            ocrefc = NCH'($urandom);
            tick();
            if ({ch_o, ch_on} !== 6'b101010) bad++;
        end
        check("t4_idle_levels", 8'(bad), 8'd0);
        ocrefc = 3'b010;
        repeat (6) tick();
        moe = 1'b1;
        tick();
        $display("t4 reenable o=%b on=%b", ch_o, ch_on);
        check("t4_reenable_o", 8'(ch_o), 8'h02);
        check("t4_reenable_on", 8'(ch_on), 8'h05);

        // timing_enable drop during DT, then restart from OFF.
        set_defaults(); dtg = 8'd3; do_reset();
        repeat (6) tick();
        ocrefc = 3'b001;
        tick(); tick();
        te = 1'b0;
        tick();
        check("t5_off", 8'({ch_o, ch_on}), 8'h00);
        te = 1'b1; dtg = 8'd2; ocrefc = 3'b111;
        tick();
        check("t5_dt_e0", 8'({ch_o, ch_on}), 8'h00);
        tick();
        check("t5_dt_e1", 8'({ch_o, ch_on}), 8'h00);
        tick();
        $display("t5 restart o=%b on=%b", ch_o, ch_on);
        check("t5_pos", 8'({ch_o, ch_on}), 8'h38);

        // Reset asserted mid-DT.
        set_defaults(); dtg = 8'd5; do_reset();
        repeat (8) tick();
        ocrefc = 3'b111;
        tick(); tick();
        srst = 1'b1;
        tick();
        check("rst_mid_dt", 8'({ch_o, ch_on}), 8'h00);
        srst = 1'b0;

`ifdef ADVTIM_DT_BREAK_EN
        set_defaults(); ois = 3'b101; oisn = 3'b010; do_reset();
        repeat (3) tick();
        check("t6_pre_on", 8'(ch_on), 8'h07);
        brk = 1'b1;
        tick(); tick();
        check("t6_flag_wait", 8'(brk_flag), 8'h00);
        tick();
        check("t6_flag_set", 8'(brk_flag), 8'h01);
        check("t6_idle", 8'({ch_o, ch_on}), 8'h2a);
        r_bif_clr = 1'b1; tick(); r_bif_clr = 1'b0;
        check("t6_clr_ignored", 8'(brk_flag), 8'h01);
        brk = 1'b0;
        repeat (3) tick();
        r_bif_clr = 1'b1; tick(); r_bif_clr = 1'b0;
        $display("t6 cleared flag=%b o=%b on=%b", brk_flag, ch_o, ch_on);
        check("t6_flag_clr", 8'(brk_flag), 8'h00);
        check("t6_active", 8'({ch_o, ch_on}), 8'h07);
`endif

        // Randomized traffic against the reference model.
        set_defaults(); do_reset();
        for (int c = 0; c < NCH; c++) begin
            m_side[c] = -1; m_dead[c] = 0; m_home[c] = -1;
        end
        for (int cyc = 0; cyc < 500; cyc++) begin
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 3) == 0) ocrefc[c] = ~ocrefc[c];
            if ($urandom_range(0, 15) == 0) dtg = DTW'($urandom_range(0, 6));
            te = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 19) == 0) moe = ~moe;
            if ($urandom_range(0, 19) == 0) begin
                cce = NCH'($urandom); ccne = NCH'($urandom);
                ccp = NCH'($urandom); ccnp = NCH'($urandom);
                ois = NCH'($urandom); oisn = NCH'($urandom);
            end
            tick();
            model_step();
            $display("rnd %0d te=%b ref=%b dtg=%0d o=%b on=%b", cyc, te, ocrefc, dtg, ch_o, ch_on);
            check("rnd_ch_o", 8'(ch_o), 8'(exp_o));
            check("rnd_ch_on", 8'(ch_on), 8'(exp_on));
            check("rnd_brk_flag", 8'(brk_flag), 8'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
